// File: rtl/branch_predictor_dual.sv
// Dual-issue fetch branch predictor: 2-bit saturating BHT fused with a tagged target buffer.
// Zero-latency lookups on the pre-update table; execute-stage training applies slot 1 then slot 2.
module branch_predictor_dual #(
    parameter int PC_W  = 11,
    parameter int IDX_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] PCF1,
    input  logic [PC_W-1:0] PCF2,
    output logic            PredictionF1,
    output logic            PredictionF2,
    output logic [PC_W-1:0] PredTargetF1,
    output logic [PC_W-1:0] PredTargetF2,
    input  logic            update_en1,
    input  logic            update_en2,
    input  logic [PC_W-1:0] PCE1,
    input  logic [PC_W-1:0] PCE2,
    input  logic            branch_taken1,
    input  logic            branch_taken2,
    input  logic [PC_W-1:0] branchAdderResultE1,
    input  logic [PC_W-1:0] branchAdderResultE2,
    input  logic            PredictionE1,
    input  logic            PredictionE2,
    output logic [15:0]     branch_count,
    output logic [15:0]     mispredict_count
);
    localparam int TAG_W = PC_W - IDX_W;
    localparam int DEPTH = 1 << IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [1:0]       ctr;
        logic [PC_W-1:0]  target;
    } entry_t;

    entry_t bht [DEPTH];

    function automatic entry_t train(entry_t e, logic [TAG_W-1:0] t, logic taken,
                                     logic [PC_W-1:0] tgt);
        entry_t r;
        r = e;
        if (e.valid && e.tag == t) begin
            if (taken) begin
                if (e.ctr != 2'd3) r.ctr = e.ctr + 2'd1;
                r.target = tgt;
            end else if (e.ctr != 2'd0) begin
                r.ctr = e.ctr - 2'd1;
            end
        end else if (taken) begin
            r.valid  = 1'b1;
            r.tag    = t;
            r.ctr    = 2'd2;
            r.target = tgt;
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_add(logic [15:0] c, logic a, logic b);
        logic [16:0] s;
        s = {1'b0, c} + 17'(a) + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [IDX_W-1:0] fidx1, fidx2, eidx1, eidx2;
    entry_t           fe1, fe2, nxt1, base2, nxt2;

    assign fidx1 = PCF1[IDX_W-1:0];
    assign fidx2 = PCF2[IDX_W-1:0];
    assign eidx1 = PCE1[IDX_W-1:0];
    assign eidx2 = PCE2[IDX_W-1:0];
    assign fe1   = bht[fidx1];
    assign fe2   = bht[fidx2];

    assign PredictionF1 = fe1.valid && (fe1.tag == PCF1[PC_W-1:IDX_W]) && fe1.ctr[1];
    assign PredictionF2 = fe2.valid && (fe2.tag == PCF2[PC_W-1:IDX_W]) && fe2.ctr[1];
    assign PredTargetF1 = (fe1.valid && (fe1.tag == PCF1[PC_W-1:IDX_W])) ? fe1.target : '0;
    assign PredTargetF2 = (fe2.valid && (fe2.tag == PCF2[PC_W-1:IDX_W])) ? fe2.target : '0;

    // Slot 2 trains on slot 1's result when both hit the same index this cycle.
    always_comb begin
        nxt1  = train(bht[eidx1], PCE1[PC_W-1:IDX_W], branch_taken1, branchAdderResultE1);
        base2 = (update_en1 && eidx1 == eidx2) ? nxt1 : bht[eidx2];
        nxt2  = train(base2, PCE2[PC_W-1:IDX_W], branch_taken2, branchAdderResultE2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht[i].valid  <= 1'b0;
                bht[i].tag    <= '0;
                bht[i].ctr    <= 2'd1;
                bht[i].target <= '0;
            end
        end else begin
            if (update_en1) bht[eidx1] <= nxt1;
            if (update_en2) bht[eidx2] <= nxt2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            branch_count     <= sat_add(branch_count, update_en1, update_en2);
            mispredict_count <= sat_add(mispredict_count,
                                        update_en1 && (branch_taken1 != PredictionE1),
                                        update_en2 && (branch_taken2 != PredictionE2));
        end
    end
endmodule

// File: tb/tb_branch_predictor_dual.sv
// Vector-table and scoreboard bench for branch_predictor_dual.
module tb_branch_predictor_dual;
    logic        clk = 0;
    logic        rst = 1;
    logic [10:0] PCF1 = 0, PCF2 = 0, PCE1 = 0, PCE2 = 0;
    logic [10:0] branchAdderResultE1 = 0, branchAdderResultE2 = 0;
    logic        update_en1 = 0, update_en2 = 0, branch_taken1 = 0, branch_taken2 = 0;
    logic        PredictionE1 = 0, PredictionE2 = 0;
    logic        PredictionF1, PredictionF2;
    logic [10:0] PredTargetF1, PredTargetF2;
    logic [15:0] branch_count, mispredict_count;

    branch_predictor_dual dut (
        .clk(clk), .rst(rst), .PCF1(PCF1), .PCF2(PCF2),
        .PredictionF1(PredictionF1), .PredictionF2(PredictionF2),
        .PredTargetF1(PredTargetF1), .PredTargetF2(PredTargetF2),
        .update_en1(update_en1), .update_en2(update_en2), .PCE1(PCE1), .PCE2(PCE2),
        .branch_taken1(branch_taken1), .branch_taken2(branch_taken2),
        .branchAdderResultE1(branchAdderResultE1), .branchAdderResultE2(branchAdderResultE2),
        .PredictionE1(PredictionE1), .PredictionE2(PredictionE2),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] pcf1, pcf2;
        logic en1; logic [10:0] pce1; logic tk1; logic [10:0] tg1; logic pe1;
        logic en2; logic [10:0] pce2; logic tk2; logic [10:0] tg2; logic pe2;
        logic xp1; logic [10:0] xt1; logic xp2; logic [10:0] xt2;
    } vec_t;

    typedef struct {
        logic xp1; logic [10:0] xt1; logic xp2; logic [10:0] xt2;
    } exp_t;

    vec_t  vecs[$];
    exp_t  sb[$];
    int    checks = 0, errors = 0;
    logic [15:0] bc_m = 0, mc_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sat(logic [15:0] c, int inc);
        int s;
        s = int'(c) + inc;
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    function automatic vec_t mk(logic [10:0] pcf1, logic [10:0] pcf2,
        logic en1, logic [10:0] pce1, logic tk1, logic [10:0] tg1, logic pe1,
        logic en2, logic [10:0] pce2, logic tk2, logic [10:0] tg2, logic pe2,
        logic xp1, logic [10:0] xt1, logic xp2, logic [10:0] xt2);
        vec_t v;
        v.pcf1 = pcf1; v.pcf2 = pcf2;
        v.en1 = en1; v.pce1 = pce1; v.tk1 = tk1; v.tg1 = tg1; v.pe1 = pe1;
        v.en2 = en2; v.pce2 = pce2; v.tk2 = tk2; v.tg2 = tg2; v.pe2 = pe2;
        v.xp1 = xp1; v.xt1 = xt1; v.xp2 = xp2; v.xt2 = xt2;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        PCF1 = v.pcf1; PCF2 = v.pcf2;
        update_en1 = v.en1; PCE1 = v.pce1; branch_taken1 = v.tk1;
        branchAdderResultE1 = v.tg1; PredictionE1 = v.pe1;
        update_en2 = v.en2; PCE2 = v.pce2; branch_taken2 = v.tk2;
        branchAdderResultE2 = v.tg2; PredictionE2 = v.pe2;
    endtask

    task automatic step_counters(input string name);
        int b, m;
        b = int'(update_en1) + int'(update_en2);
        m = int'(update_en1 && (branch_taken1 != PredictionE1)) +
            int'(update_en2 && (branch_taken2 != PredictionE2));
        @(posedge clk);
        bc_m = sat(bc_m, b);
        mc_m = sat(mc_m, m);
        #1;
        chk({name, "_bc"}, 32'(branch_count), 32'(bc_m));
        chk({name, "_mc"}, 32'(mispredict_count), 32'(mc_m));
    endtask

    initial begin
        exp_t e;
        vec_t idle;
        idle = mk(0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0);

        // pcf1 pcf2 | en1 pce1 tk1 tg1 pe1 | en2 pce2 tk2 tg2 pe2 | xp1 xt1 xp2 xt2
        vecs.push_back(mk(11'h010,0, 0,0,0,0,0,                 0,0,0,0,0,                 0,0,0,0));
        vecs.push_back(mk(11'h010,0, 1,11'h010,1,11'h123,0,     0,0,0,0,0,                 0,0,0,0));
        vecs.push_back(mk(11'h010,0, 1,11'h010,0,0,1,           0,0,0,0,0,                 1,11'h123,0,0));
        vecs.push_back(mk(11'h010,0, 1,11'h010,0,0,0,           0,0,0,0,0,                 0,11'h123,0,0));
        vecs.push_back(mk(11'h010,0, 1,11'h010,0,0,0,           0,0,0,0,0,                 0,11'h123,0,0));
        vecs.push_back(mk(11'h010,0, 1,11'h010,1,11'h123,0,     0,0,0,0,0,                 0,11'h123,0,0));
        vecs.push_back(mk(11'h010,0, 1,11'h010,1,11'h123,0,     0,0,0,0,0,                 0,11'h123,0,0));
        vecs.push_back(mk(11'h010,11'h050, 0,0,0,0,0,           0,0,0,0,0,                 1,11'h123,0,0));
        vecs.push_back(mk(11'h010,11'h050, 1,11'h050,1,11'h055,0, 0,0,0,0,0,               1,11'h123,0,0));
        vecs.push_back(mk(11'h010,11'h050, 0,0,0,0,0,           0,0,0,0,0,                 0,0,1,11'h055));
        vecs.push_back(mk(11'h020,0, 1,11'h020,1,11'h200,0,     0,0,0,0,0,                 0,0,0,0));
        vecs.push_back(mk(11'h020,0, 1,11'h020,0,0,1,           0,0,0,0,0,                 1,11'h200,0,0));
        vecs.push_back(mk(11'h020,0, 1,11'h020,1,11'h200,0,     1,11'h020,1,11'h210,0,     0,11'h200,0,0));
        vecs.push_back(mk(11'h020,0, 1,11'h020,0,0,1,           1,11'h020,0,0,1,           1,11'h210,0,0));
        vecs.push_back(mk(11'h020,0, 1,11'h020,1,11'h210,0,     1,11'h020,0,11'h3FF,1,     0,11'h210,0,0));
        vecs.push_back(mk(11'h020,0, 0,0,0,0,0,                 0,0,0,0,0,                 0,11'h210,0,0));
        vecs.push_back(mk(0,11'h030, 1,11'h030,1,11'h111,0,     1,11'h030,1,11'h222,0,     0,0,0,0));
        vecs.push_back(mk(0,11'h030, 0,11'h040,1,11'h444,0,     0,0,0,0,0,                 0,0,1,11'h222));
        vecs.push_back(mk(11'h040,11'h010, 0,0,0,0,0,           0,0,0,0,0,                 0,0,0,0));

        PCF1 = 11'h010;
        #3;
        chk("rst_p1", 32'(PredictionF1), 0);
        chk("rst_t1", 32'(PredTargetF1), 0);
        chk("rst_bc", 32'(branch_count), 0);
        chk("rst_mc", 32'(mispredict_count), 0);
        @(negedge clk); rst = 0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            e.xp1 = vecs[i].xp1; e.xt1 = vecs[i].xt1; e.xp2 = vecs[i].xp2; e.xt2 = vecs[i].xt2;
            sb.push_back(e);
            #2;
            e = sb.pop_front();
            chk($sformatf("v%0d_p1", i), 32'(PredictionF1), 32'(e.xp1));
            chk($sformatf("v%0d_t1", i), 32'(PredTargetF1), 32'(e.xt1));
            chk($sformatf("v%0d_p2", i), 32'(PredictionF2), 32'(e.xp2));
            chk($sformatf("v%0d_t2", i), 32'(PredTargetF2), 32'(e.xt2));
            step_counters($sformatf("v%0d", i));
        end

        // Drive the mispredict counter up to FFFE with not-taken mispredicts (no allocation).
        for (int n = 0; n < 40000 && mc_m < 16'hFFFE; n++) begin
            @(negedge clk);
            drive(idle);
            update_en1 = 1; PCE1 = 11'h03F; PredictionE1 = 1;
            if (16'hFFFE - mc_m >= 2) begin
                update_en2 = 1; PCE2 = 11'h03F; PredictionE2 = 1;
            end
            @(posedge clk);
            bc_m = sat(bc_m, int'(update_en1) + int'(update_en2));
            mc_m = sat(mc_m, int'(update_en1) + int'(update_en2));
        end
        #1;
        chk("pre_sat_mc", 32'(mispredict_count), 32'h0000FFFE);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(idle);
            update_en1 = 1; PCE1 = 11'h03F; PredictionE1 = 1;
            update_en2 = 1; PCE2 = 11'h03F; PredictionE2 = 1;
            step_counters($sformatf("sat%0d", k));
            chk($sformatf("sat%0d_abs", k), 32'(mispredict_count), 32'h0000FFFF);
        end

        // Reset in the middle of a cycle carrying a taken update.
        @(negedge clk);
        drive(idle);
        PCF1 = 11'h00A; PCF2 = 11'h050;
        update_en1 = 1; PCE1 = 11'h00A; branch_taken1 = 1; branchAdderResultE1 = 11'h0AA;
        #2 rst = 1;
        #1;
        chk("mrst_p2", 32'(PredictionF2), 0);
        chk("mrst_t2", 32'(PredTargetF2), 0);
        chk("mrst_bc", 32'(branch_count), 0);
        chk("mrst_mc", 32'(mispredict_count), 0);
        @(negedge clk);
        update_en1 = 0;
        rst = 0;
        #1;
        chk("post_p1", 32'(PredictionF1), 0);
        chk("post_t1", 32'(PredTargetF1), 0);
        chk("post_p2", 32'(PredictionF2), 0);
        chk("post_bc", 32'(branch_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor_dual.md
Name: branch_predictor_dual

Overview:
- Dual-issue fetch-side branch predictor: a 2-bit saturating-counter BHT combined with a tagged target buffer.
- Drives PredictionF1/F2 and predicted targets into fetch. These predictions are pipelined to execute as PredictionE1/E2, where the PC correction logic consumes them.
- Trains from execute-stage branch outcomes and keeps saturating branch/mispredict statistics counters.

Parameters:
- PC_W, 11, PC width (word address).
- IDX_W, 6, table index width; 2^IDX_W entries. Tag width TAG_W = PC_W-IDX_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCF1, PCF2  in  PC_W  fetch PCs for slot 1 and slot 2.
- PredictionF1, PredictionF2  out  1  predict taken for the slot.
- PredTargetF1, PredTargetF2  out  PC_W  predicted target for the slot.
- update_en1, update_en2  in  1  slot carries a resolved conditional branch in execute.
- PCE1, PCE2  in  PC_W  PC of the execute-stage branch.
- branch_taken1, branch_taken2  in  1  resolved direction.
- branchAdderResultE1, branchAdderResultE2  in  PC_W  resolved target.
- PredictionE1, PredictionE2  in  1  prediction originally made for that branch.
- branch_count  out  16  number of resolved branches, saturating.
- mispredict_count  out  16  number of mispredicted branches, saturating.

Behaviour:
- Entry fields: valid(1), tag(TAG_W), ctr(2), target(PC_W).
- Index is PC[IDX_W-1:0]; tag is PC[PC_W-1:IDX_W].
- Lookup is combinational from table state; zero-latency, same cycle as PCF.
- hitN = valid & (tag == PCFN tag).
- PredictionFN = hitN & ctr[1].
- PredTargetFN = target on hit, else 0.
- Lookups read the pre-update table. A write in cycle t is visible to lookups from cycle t+1; there is no bypass.
- Update is sequential, on the clk rising edge, for each slot with update_enN=1 at the indexed entry:
  - Tag match & valid: ctr saturates toward taken (+1, max 3) or not-taken (-1, min 0).
  - Miss or invalid, branch taken: allocate the entry. valid=1, tag written, ctr=2 (weakly taken), target written.
  - Miss or invalid, branch not taken: no allocation and no change.
  - Target is written on allocate, and on any taken update whose branchAdderResultE differs from the stored target.
- Both slots updating the same index in one cycle: apply slot 1 then slot 2 sequentially.
  - Result is f2(f1(entry)). Slot 2 sees slot 1's effect, including its allocation and tag.
  - Net ctr change may therefore be ±2, or 0 for opposing outcomes. Slot 2 wins on target and tag.
- Statistics, each rising edge:
  - branch_count += update_en1 + update_en2.
  - mispredict_count += (update_en1 & (branch_taken1 != PredictionE1)) + (update_en2 & (branch_taken2 != PredictionE2)).
  - Both counters saturate at 16'hFFFF; an increment of 2 from FFFE gives FFFF.
- Reset (asynchronous, any time, including mid-update):
  - Every entry is cleared: valid=0, ctr=1, tag=0, target=0.
  - Both counters go to 0.
  - All PredictionF outputs read 0 and all PredTargetF outputs read 0 while rst is high and immediately after release.
- Reset release is synchronised by the integrating design; the block has no internal pending state beyond the table and the counters.
- PCF1 and PCF2 aliasing to the same index: both read the same entry independently. No conflict and no priority.
- update_enN=0: the slot's other execute inputs are ignored.

Test Plan:
- Reset, then PCF1=11'h010 → PredictionF1=0, PredTargetF1=0. Both counters read 0.
- update_en1, PCE1=11'h010, taken, target=11'h123, PredictionE1=0 → next cycle PCF1=11'h010 gives PredictionF1=1, PredTargetF1=11'h123. Same cycle as the update, PredictionF1 is still 0. mispredict_count=1, branch_count=1.
- Three not-taken updates to 11'h010 after allocation → ctr 2→1→0→0, PredictionF1=0 after the first. Two taken updates → 0→1→2, predict taken again.
- Tag alias: entry allocated by 11'h010, lookup at PCF2=11'h050 (same index, different tag) → PredictionF2=0. A taken update at 11'h050 replaces the entry; 11'h010 then misses.
- Same-index dual update in one cycle on a valid entry with ctr=1: slot 1 taken, slot 2 taken → ctr=3. With slot 1 taken, slot 2 not taken → ctr=1 and target unchanged by slot 2.
- Force mispredict_count to 16'hFFFE, then a dual mispredict → 16'hFFFF and it holds. Assert rst mid-cycle during an update → table and counters clear immediately and no write lands.
